// File: rtl/reg_file_mp_pkg.sv
// Shared constants and helpers for the multi-port register file: default sizes,
// an address-width function and port-slice offset helpers for decode/writeback.
package reg_file_mp_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int NRD_DEFAULT   = 2;
    localparam int NWR_DEFAULT   = 2;

    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Low bit of port 'port' inside a flattened bus of 'width'-bit fields.
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback bus of the register file: read ports, write ports, destination
// claim and the busy vector.
interface reg_file_mp_if
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int NREGS = NREGS_DEFAULT,
    parameter int NRD   = NRD_DEFAULT,
    parameter int NWR   = NWR_DEFAULT
);
    localparam int AW = clog2_f(NREGS);

    logic [NRD*AW-1:0]   read_sel;
    logic [NRD*XLEN-1:0] read_data;
    logic [NRD-1:0]      read_busy;
    logic [NWR-1:0]      wEn;
    logic [NWR*AW-1:0]   write_sel;
    logic [NWR*XLEN-1:0] write_data;
    logic                claim_en;
    logic [AW-1:0]       claim_sel;
    logic [NREGS-1:0]    busy_vec;

    modport master (
        output read_sel, wEn, write_sel, write_data, claim_en, claim_sel,
        input  read_data, read_busy, busy_vec
    );

    modport slave (
        input  read_sel, wEn, write_sel, write_data, claim_en, claim_sel,
        output read_data, read_busy, busy_vec
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: decode claims set a bit, writebacks release it,
// and a claim in the same cycle as a release wins.
module rf_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NWR      = NWR_DEFAULT,
    parameter int ZERO_REG = 1,
    parameter int AW       = clog2_f(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              claim_en,
    input  logic [AW-1:0]     claim_sel,
    input  logic [NWR-1:0]    wEn,
    input  logic [NWR*AW-1:0] write_sel,
    output logic [NREGS-1:0]  release_vec,
    output logic [NREGS-1:0]  busy_vec
);

    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] busy_next;

    always_comb begin
        set_vec     = '0;
        release_vec = '0;
        if (claim_en) begin
            set_vec[claim_sel] = 1'b1;
        end
        for (int w = 0; w < NWR; w++) begin
            if (wEn[w]) begin
                release_vec[write_sel[slice_lo(w, AW) +: AW]] = 1'b1;
            end
        end
        busy_next = (busy_vec & ~release_vec) | set_vec;
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_vec <= '0;
        end else begin
            busy_vec <= busy_next;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with prioritised writeback ports, optional
// write-to-read bypass and a busy scoreboard for issued destinations.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NRD      = NRD_DEFAULT,
    parameter int NWR      = NWR_DEFAULT,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic           clock,
    input logic           reset,
    reg_file_mp_if.slave  bus
);

    localparam int AW = clog2_f(NREGS);

    logic [XLEN-1:0]     mem [NREGS];
    logic [NREGS-1:0]    release_vec;
    logic [NREGS-1:0]    busy_vec;
    logic [NRD*XLEN-1:0] read_data;
    logic [NRD-1:0]      read_busy;
    logic [AW-1:0]       rsel;
    logic [XLEN-1:0]     rval;

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clock       (clock),
        .reset       (reset),
        .claim_en    (bus.claim_en),
        .claim_sel   (bus.claim_sel),
        .wEn         (bus.wEn),
        .write_sel   (bus.write_sel),
        .release_vec (release_vec),
        .busy_vec    (busy_vec)
    );

    // Ports are visited in ascending order so the highest-index writer lands last.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (bus.wEn[w] &&
                    !((ZERO_REG != 0) && (bus.write_sel[slice_lo(w, AW) +: AW] == '0))) begin
                    mem[bus.write_sel[slice_lo(w, AW) +: AW]] <= bus.write_data[slice_lo(w, XLEN) +: XLEN];
                end
            end
        end
    end

    // Reset low forces zero even over bypassed write data.
    always_comb begin
        read_data = '0;
        read_busy = '0;
        rsel      = '0;
        rval      = '0;
        for (int r = 0; r < NRD; r++) begin
            rsel = bus.read_sel[slice_lo(r, AW) +: AW];
            rval = mem[rsel];
            if (BYPASS != 0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (bus.wEn[w] && (bus.write_sel[slice_lo(w, AW) +: AW] == rsel)) begin
                        rval = bus.write_data[slice_lo(w, XLEN) +: XLEN];
                    end
                end
            end
            if ((ZERO_REG != 0) && (rsel == '0)) begin
                rval = '0;
            end
            if (!reset) begin
                rval = '0;
            end
            read_data[slice_lo(r, XLEN) +: XLEN] = rval;
            if (BYPASS != 0) begin
                read_busy[r] = busy_vec[rsel] & ~release_vec[rsel];
            end else begin
                read_busy[r] = busy_vec[rsel];
            end
        end
    end

    assign bus.read_data = read_data;
    assign bus.read_busy = read_busy;
    assign bus.busy_vec  = busy_vec;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a default bypassing instance and a wide non-bypassing
// instance, directed scenarios plus randomised runs against an array model.
module tb_reg_file_mp;

    localparam int AWA = 5;
    localparam int AWB = 6;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    int unsigned mdl_mem [64];
    logic [63:0] mdl_busy;

    reg_file_mp_if #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2)) ifa ();
    reg_file_mp_if #(.XLEN(32), .NREGS(64), .NRD(4), .NWR(3)) ifb ();

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (ifa.slave)
    );

    reg_file_mp #(.XLEN(32), .NREGS(64), .NRD(4), .NWR(3), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (ifb.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] rd_a(input int r);
        return ifa.read_data[r*32 +: 32];
    endfunction

    function automatic logic [31:0] rd_b(input int r);
        return ifb.read_data[r*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ifa.read_sel = '0; ifa.wEn = '0; ifa.write_sel = '0; ifa.write_data = '0;
        ifa.claim_en = 1'b0; ifa.claim_sel = '0;
        ifb.read_sel = '0; ifb.wEn = '0; ifb.write_sel = '0; ifb.write_data = '0;
        ifb.claim_en = 1'b0; ifb.claim_sel = '0;
    endtask

    task automatic write_a(input int port, input int sel, input logic [31:0] data);
        ifa.wEn[port] = 1'b1;
        ifa.write_sel[port*AWA +: AWA] = sel[AWA-1:0];
        ifa.write_data[port*32 +: 32] = data;
    endtask

    task automatic write_b(input int port, input int sel, input logic [31:0] data);
        ifb.wEn[port] = 1'b1;
        ifb.write_sel[port*AWB +: AWB] = sel[AWB-1:0];
        ifb.write_data[port*32 +: 32] = data;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2;
        total++; if (ifa.busy_vec !== 32'h0) begin bad++; $display("FAIL reset_busy_vec: got %h want 0", ifa.busy_vec); end
        total++; if (rd_a(0) !== 32'h0) begin bad++; $display("FAIL reset_read: got %h want 0", rd_a(0)); end
        @(negedge clock) reset = 1'b1;
        tick();
        write_a(0, 5, 32'hDEADBEEF);
        ifa.claim_en = 1'b1; ifa.claim_sel = 5'd5;
        tick();
        idle_inputs();
        ifa.read_sel[0 +: AWA] = 5'd5;
        #1;
        total++; if (rd_a(0) !== 32'hDEADBEEF) begin bad++; $display("FAIL reset_prewrite: got %h want deadbeef", rd_a(0)); end
        total++; if (ifa.busy_vec[5] !== 1'b1) begin bad++; $display("FAIL reset_preclaim: got %b want 1", ifa.busy_vec[5]); end
        #1 reset = 1'b0;
        write_a(1, 5, 32'h55);
        #1;
        total++; if (rd_a(0) !== 32'h0) begin bad++; $display("FAIL reset_async_read: got %h want 0", rd_a(0)); end
        total++; if (ifa.busy_vec !== 32'h0) begin bad++; $display("FAIL reset_async_busy: got %h want 0", ifa.busy_vec); end
        total++; if (ifa.read_busy !== 2'b00) begin bad++; $display("FAIL reset_async_rbusy: got %b want 00", ifa.read_busy); end
        tick();
        idle_inputs();
        ifa.read_sel[0 +: AWA] = 5'd5;
        @(negedge clock) reset = 1'b1;
        #1;
        total++; if (rd_a(0) !== 32'h0) begin bad++; $display("FAIL reset_held_read: got %h want 0", rd_a(0)); end
        tick();
    endtask

    task automatic test_write_conflict();
        idle_inputs();
        write_a(0, 7, 32'h11);
        write_a(1, 7, 32'h22);
        ifa.read_sel[0 +: AWA] = 5'd7;
        #1;
        total++; if (rd_a(0) !== 32'h22) begin bad++; $display("FAIL conflict_bypass: got %h want 22", rd_a(0)); end
        tick();
        idle_inputs();
        ifa.read_sel[0 +: AWA] = 5'd7;
        #1;
        total++; if (rd_a(0) !== 32'h22) begin bad++; $display("FAIL conflict_stored: got %h want 22", rd_a(0)); end
    endtask

    task automatic test_bypass();
        idle_inputs();
        write_a(0, 3, 32'h1111);
        write_b(0, 3, 32'h1111);
        tick();
        idle_inputs();
        write_a(1, 3, 32'hCAFE);
        write_b(1, 3, 32'hCAFE);
        ifa.read_sel[0 +: AWA] = 5'd3;
        ifa.read_sel[AWA +: AWA] = 5'd4;
        ifb.read_sel[0 +: AWB] = 6'd3;
        #1;
        total++; if (rd_a(0) !== 32'hCAFE) begin bad++; $display("FAIL bypass_on: got %h want cafe", rd_a(0)); end
        total++; if (rd_a(1) !== 32'h0) begin bad++; $display("FAIL bypass_other_port: got %h want 0", rd_a(1)); end
        total++; if (rd_b(0) !== 32'h1111) begin bad++; $display("FAIL bypass_off_old: got %h want 1111", rd_b(0)); end
        tick();
        idle_inputs();
        ifa.read_sel[0 +: AWA] = 5'd3;
        ifb.read_sel[0 +: AWB] = 6'd3;
        #1;
        total++; if (rd_b(0) !== 32'hCAFE) begin bad++; $display("FAIL bypass_off_new: got %h want cafe", rd_b(0)); end
        total++; if (rd_a(0) !== 32'hCAFE) begin bad++; $display("FAIL bypass_on_stored: got %h want cafe", rd_a(0)); end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        write_a(0, 0, 32'h1234);
        write_a(1, 0, 32'h1234);
        ifa.claim_en = 1'b1; ifa.claim_sel = 5'd0;
        write_b(2, 0, 32'h1234);
        #1;
        total++; if (rd_a(0) !== 32'h0) begin bad++; $display("FAIL zero_bypass_p0: got %h want 0", rd_a(0)); end
        total++; if (rd_a(1) !== 32'h0) begin bad++; $display("FAIL zero_bypass_p1: got %h want 0", rd_a(1)); end
        tick();
        idle_inputs();
        #1;
        total++; if (rd_a(0) !== 32'h0) begin bad++; $display("FAIL zero_stored_a: got %h want 0", rd_a(0)); end
        total++; if (rd_b(0) !== 32'h0) begin bad++; $display("FAIL zero_stored_b: got %h want 0", rd_b(0)); end
        total++; if (ifa.busy_vec[0] !== 1'b0) begin bad++; $display("FAIL zero_busy: got %b want 0", ifa.busy_vec[0]); end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        ifa.claim_en = 1'b1; ifa.claim_sel = 5'd9;
        ifa.read_sel[0 +: AWA] = 5'd9;
        #1;
        total++; if (ifa.read_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_claim_same_cycle: got %b want 0", ifa.read_busy[0]); end
        tick();
        idle_inputs();
        ifa.read_sel[0 +: AWA] = 5'd9;
        #1;
        total++; if (ifa.busy_vec[9] !== 1'b1) begin bad++; $display("FAIL sb_claimed: got %b want 1", ifa.busy_vec[9]); end
        total++; if (ifa.read_busy[0] !== 1'b1) begin bad++; $display("FAIL sb_read_busy: got %b want 1", ifa.read_busy[0]); end
        ifa.claim_en = 1'b1; ifa.claim_sel = 5'd9;
        write_a(0, 9, 32'hAB);
        #1;
        total++; if (ifa.read_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_release_bypass: got %b want 0", ifa.read_busy[0]); end
        tick();
        idle_inputs();
        ifa.read_sel[0 +: AWA] = 5'd9;
        #1;
        total++; if (ifa.busy_vec[9] !== 1'b1) begin bad++; $display("FAIL sb_claim_wins: got %b want 1", ifa.busy_vec[9]); end
        write_a(1, 9, 32'hCD);
        #1;
        total++; if (ifa.read_busy[0] !== 1'b0) begin bad++; $display("FAIL sb_release_now: got %b want 0", ifa.read_busy[0]); end
        tick();
        idle_inputs();
        ifa.read_sel[0 +: AWA] = 5'd9;
        #1;
        total++; if (ifa.busy_vec[9] !== 1'b0) begin bad++; $display("FAIL sb_released: got %b want 0", ifa.busy_vec[9]); end
        total++; if (rd_a(0) !== 32'hCD) begin bad++; $display("FAIL sb_data: got %h want cd", rd_a(0)); end
        write_a(0, 10, 32'h1);
        tick();
        idle_inputs();
        #1;
        total++; if (ifa.busy_vec[10] !== 1'b0) begin bad++; $display("FAIL sb_nonbusy_write: got %b want 0", ifa.busy_vec[10]); end
    endtask

    // Model: array of register values plus a busy set, updated once per clock.
    task automatic test_random(input int which, input int cycles);
        int nregs, nrd, nwr;
        bit byp, ce, any_wr;
        int unsigned rs [4];
        int unsigned ws [3];
        int unsigned wd [3];
        bit we [3];
        int unsigned cs;
        logic [31:0] exp_d, act_d;
        logic exp_b, act_b;
        logic [63:0] rel, exp_vec, act_vec;
        nregs = (which == 0) ? 32 : 64;
        nrd   = (which == 0) ? 2 : 4;
        nwr   = (which == 0) ? 2 : 3;
        byp   = (which == 0);
        idle_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < 64; i++) mdl_mem[i] = 0;
        mdl_busy = '0;
        for (int c = 0; c < cycles; c++) begin
            idle_inputs();
            for (int w = 0; w < nwr; w++) begin
                we[w] = ($urandom_range(0, 1) == 1);
                ws[w] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(0, nregs - 1);
                wd[w] = $urandom;
                if (we[w]) begin
                    if (which == 0) write_a(w, int'(ws[w]), wd[w]);
                    else write_b(w, int'(ws[w]), wd[w]);
                end
            end
            ce = ($urandom_range(0, 2) == 0);
            cs = ($urandom_range(0, 3) == 0) ? ws[0] : $urandom_range(0, nregs - 1);
            for (int r = 0; r < nrd; r++) begin
                rs[r] = ($urandom_range(0, 1) == 1) ? ws[$urandom_range(0, nwr - 1)] : $urandom_range(0, nregs - 1);
            end
            if (which == 0) begin
                ifa.claim_en = ce; ifa.claim_sel = cs[AWA-1:0];
                for (int r = 0; r < nrd; r++) ifa.read_sel[r*AWA +: AWA] = rs[r][AWA-1:0];
            end else begin
                ifb.claim_en = ce; ifb.claim_sel = cs[AWB-1:0];
                for (int r = 0; r < nrd; r++) ifb.read_sel[r*AWB +: AWB] = rs[r][AWB-1:0];
            end
            #1;
            for (int r = 0; r < nrd; r++) begin
                any_wr = 1'b0;
                exp_d = mdl_mem[rs[r]];
                for (int w = 0; w < nwr; w++) begin
                    if (we[w] && ws[w] == rs[r]) begin
                        any_wr = 1'b1;
                        if (byp) exp_d = wd[w];
                    end
                end
                if (rs[r] == 0) exp_d = 32'h0;
                exp_b = mdl_busy[rs[r]] && !(byp && any_wr);
                act_d = (which == 0) ? rd_a(r) : rd_b(r);
                act_b = (which == 0) ? ifa.read_busy[r] : ifb.read_busy[r];
                total++; if (act_d !== exp_d) begin bad++; $display("FAIL rand%0d_data cyc %0d port %0d sel %0d: got %h want %h", which, c, r, rs[r], act_d, exp_d); end
                total++; if (act_b !== exp_b) begin bad++; $display("FAIL rand%0d_rbusy cyc %0d port %0d sel %0d: got %b want %b", which, c, r, rs[r], act_b, exp_b); end
            end
            exp_vec = (which == 0) ? {32'h0, mdl_busy[31:0]} : mdl_busy;
            act_vec = (which == 0) ? {32'h0, ifa.busy_vec} : ifb.busy_vec;
            total++; if (act_vec !== exp_vec) begin bad++; $display("FAIL rand%0d_busy_vec cyc %0d: got %h want %h", which, c, act_vec, exp_vec); end
            tick();
            rel = '0;
            for (int w = 0; w < nwr; w++) begin
                if (we[w]) begin
                    rel[ws[w]] = 1'b1;
                    if (ws[w] != 0) mdl_mem[ws[w]] = wd[w];
                end
            end
            mdl_busy = mdl_busy & ~rel;
            if (ce && cs != 0) mdl_busy[cs] = 1'b1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        test_reset();
        test_write_conflict();
        test_bypass();
        test_zero_reg();
        test_scoreboard();
        test_random(0, 2000);
        test_random(1, 10000);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        bad++;
        $display("FAIL watchdog: simulation still running at %0t, limit 1000000", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
